// File: rtl/apb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_master_arbiter: round-robin sharing of one APB completer by NREQ masters|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 prst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [AW-1:0]        paddr,
  output logic [DW-1:0]        pwdata,
  input  logic                 pready,
  input  logic [DW-1:0]        prdata
);

  localparam int c_iw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_cw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_iw-1:0] c_last_init = c_iw'(NREQ - 1);
  localparam logic [c_cw-1:0] c_cnt_max   = c_cw'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_iw-1:0]   r_last_grant, w_last_grant_nxt;
  logic [c_iw-1:0]   r_owner, w_owner_nxt;
  logic [c_iw-1:0]   w_winner;
  logic              w_any;
  logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
  logic              w_psel_nxt, w_penable_nxt, w_pwrite_nxt, w_rsp_err_nxt;
  logic [AW-1:0]     w_paddr_nxt;
  logic [DW-1:0]     w_pwdata_nxt, w_rsp_rdata_nxt;
  logic [NREQ-1:0]   w_rsp_valid_nxt;
  logic [AW-1:0]     w_addr  [NREQ];
  logic [DW-1:0]     w_wdata [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr[g]  = req_addr[g*AW +: AW];
    assign w_wdata[g] = req_wdata[g*DW +: DW];
  end

  // Scan from the lowest priority (last_grant itself) upward so the lowest
  // rotation offset overrides and wins.
  always_comb begin
    int cand;
    cand     = 0;
    w_any    = 1'b0;
    w_winner = r_last_grant;
    for (int k = NREQ; k >= 1; k--) begin
      cand = int'(r_last_grant) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_valid[c_iw'(cand)]) begin
        w_any    = 1'b1;
        w_winner = c_iw'(cand);
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_owner_nxt      = r_owner;
    w_cnt_nxt        = r_cnt;
    w_psel_nxt       = psel;
    w_penable_nxt    = penable;
    w_pwrite_nxt     = pwrite;
    w_paddr_nxt      = paddr;
    w_pwdata_nxt     = pwdata;
    w_rsp_valid_nxt  = '0;
    w_rsp_rdata_nxt  = rsp_rdata;
    w_rsp_err_nxt    = rsp_err;
    req_ready        = '0;

    case (r_state)
      S_IDLE: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        if (w_any) begin
          req_ready[w_winner] = 1'b1;
          w_last_grant_nxt    = w_winner;
          w_owner_nxt         = w_winner;
          w_psel_nxt          = 1'b1;
          w_pwrite_nxt        = req_write[w_winner];
          w_paddr_nxt         = w_addr[w_winner];
          w_pwdata_nxt        = req_write[w_winner] ? w_wdata[w_winner] : '0;
          w_state_nxt         = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          w_psel_nxt               = 1'b0;
          w_penable_nxt            = 1'b0;
          w_rsp_valid_nxt[r_owner] = 1'b1;
          w_rsp_err_nxt            = 1'b0;
          w_rsp_rdata_nxt          = pwrite ? '0 : prdata;
          w_cnt_nxt                = '0;
          w_state_nxt              = S_IDLE;
        end else if (r_cnt == c_cnt_max) begin
          // Hung completer: abort and report the error to the owner.
          w_psel_nxt               = 1'b0;
          w_penable_nxt            = 1'b0;
          w_rsp_valid_nxt[r_owner] = 1'b1;
          w_rsp_err_nxt            = 1'b1;
          w_rsp_rdata_nxt          = '0;
          w_cnt_nxt                = '0;
          w_state_nxt              = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state      <= S_IDLE;
      r_last_grant <= c_last_init;
      r_owner      <= '0;
      r_cnt        <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_cnt        <= w_cnt_nxt;
      psel         <= w_psel_nxt;
      penable      <= w_penable_nxt;
      pwrite       <= w_pwrite_nxt;
      paddr        <= w_paddr_nxt;
      pwdata       <= w_pwdata_nxt;
      rsp_valid    <= w_rsp_valid_nxt;
      rsp_rdata    <= w_rsp_rdata_nxt;
      rsp_err      <= w_rsp_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// tb_apb_master_arbiter: directed + random stimulus checked against a transaction-level
// model of the arbiter (round-robin pick, latency in cycles since acceptance).
module tb_apb_master_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 6;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic                 pclk = 1'b0;
  logic                 prst;
  logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        rsp_rdata, pwdata, prdata;
  logic                 rsp_err, psel, penable, pwrite, pready;
  logic [AW-1:0]        paddr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  // Reference model state
  int              m_last;
  bit              m_busy;
  int              m_age;       // cycles since acceptance; ACCESS cycle count = m_age-1
  int              m_owner;
  bit              m_write;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [NREQ-1:0] e_rsp_valid;
  logic [DW-1:0]   e_rdata;
  bit              e_err, e_psel, e_penable;
  logic [NREQ-1:0] acc_mask;
  logic            p_psel, p_pwrite;
  logic [AW-1:0]   p_paddr;
  logic [NREQ-1:0] p_rsp_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_last = NREQ - 1; m_busy = 0; m_age = 0; m_owner = 0; m_write = 0;
    m_addr = '0; m_wdata = '0; e_rsp_valid = '0; e_rdata = '0; e_err = 0;
    e_psel = 0; e_penable = 0; acc_mask = '0;
    p_psel = 0; p_pwrite = 0; p_paddr = '0; p_rsp_valid = '0;
  endtask

  function automatic logic [NREQ-1:0] arb_pick();
    logic [NREQ-1:0] r;
    int c;
    r = '0;
    if (m_busy) return r;
    for (int k = 1; k <= NREQ; k++) begin
      c = (m_last + k) % NREQ;
      if (req_valid[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic complete(input bit err, input logic [DW-1:0] rd);
    e_rsp_valid          = '0;
    e_rsp_valid[m_owner] = 1'b1;
    e_err = err; e_rdata = rd; e_psel = 0; e_penable = 0; m_busy = 0;
  endtask

  task automatic model_advance(input logic [NREQ-1:0] pick);
    e_rsp_valid = '0;
    if (!m_busy) begin
      if (pick != 0) begin
        for (int i = 0; i < NREQ; i++) if (pick[i]) m_owner = i;
        m_last  = m_owner; m_busy = 1; m_age = 1;
        m_write = req_write[m_owner];
        m_addr  = req_addr[m_owner*AW +: AW];
        m_wdata = req_wdata[m_owner*DW +: DW];
        e_psel  = 1; e_penable = 0;
      end
    end else if (m_age == 1) begin
      m_age = 2; e_penable = 1;
    end else if (pready) begin
      complete(0, m_write ? '0 : prdata);
    end else if (m_age - 1 >= TIMEOUT) begin
      complete(1, '0);
    end else begin
      m_age++;
    end
  endtask

  task automatic check_outputs();
    chk("psel", psel, e_psel);
    chk("penable", penable, e_penable);
    chk("rsp_valid", rsp_valid, e_rsp_valid);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    if (e_rsp_valid != 0) chk("rsp_err", rsp_err, e_err);
    if (e_psel) begin
      chk("paddr", paddr, m_addr);
      chk("pwrite", pwrite, m_write);
      chk("pwdata", pwdata, m_write ? m_wdata : '0);
    end
    chk("apb_setup_first", penable & ~p_psel, 0);
    if (psel & p_psel) chk("apb_stable", {paddr, pwrite}, {p_paddr, p_pwrite});
    chk("rsp_pulse", |(rsp_valid & p_rsp_valid), 0);
    p_psel = psel; p_pwrite = pwrite; p_paddr = paddr; p_rsp_valid = rsp_valid;
  endtask

  // Inputs must be driven before calling; samples outputs 1 time unit after the edge.
  task automatic step();
    logic [NREQ-1:0] pick;
    #1;
    pick = arb_pick();
    chk("req_ready", req_ready, pick);
    acc_mask = pick;
    model_advance(pick);
    @(posedge pclk);
    #1;
    check_outputs();
  endtask

  task automatic set_req(input int i, input bit v, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int n_acc;
    bit got;
    int ng;
    int g_idx [4];
    int g_cyc [4];

    prst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_psel", psel, 0);       chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);   chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);   chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0); chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 0);
    #4 prst = 1'b0;

    // 1: write from requester 0, zero wait states
    set_req(0, 1, 1, 6'h05, 32'hDEADBEEF); pready = 1'b1; prdata = 32'hA5A5A5A5;
    #1 chk("t1_ready", req_ready, 2'b01);
    step();
    chk("t1_setup_psel", psel, 1); chk("t1_setup_penable", penable, 0);
    set_req(0, 0, 0, '0, '0);
    step();
    chk("t1_access_penable", penable, 1); chk("t1_paddr", paddr, 6'h05);
    chk("t1_pwdata", pwdata, 32'hDEADBEEF); chk("t1_pwrite", pwrite, 1);
    step();
    chk("t1_rsp_valid", rsp_valid, 2'b01); chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_rdata", rsp_rdata, 0); chk("t1_psel_off", psel, 0);

    // 2: read from requester 1 with 3 wait states
    set_req(1, 1, 0, 6'h05, 32'hFFFFFFFF); pready = 1'b0; prdata = '0;
    step();
    set_req(1, 0, 0, '0, '0);
    chk("t2_pwdata_read", pwdata, 0);
    n_acc = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (psel && penable) begin
        n_acc++;
        chk("t2_paddr_stable", paddr, 6'h05);
      end
      pready = (n_acc == 4);
      prdata = (n_acc == 4) ? 32'h12345678 : 32'h0;
      step();
      if (rsp_valid != 0) got = 1;
    end
    chk("t2_done", got, 1); chk("t2_access_cycles", n_acc, 4);
    chk("t2_rsp_valid", rsp_valid, 2'b10); chk("t2_rsp_rdata", rsp_rdata, 32'h12345678);

    // 3: both requesters continuously valid -> alternating grants 3 cycles apart
    set_req(0, 1, 0, 6'h11, '0); set_req(1, 1, 0, 6'h22, '0); pready = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      prdata = $urandom | 32'h1;
      #1;
      if (req_ready != 0) begin
        g_idx[ng] = (req_ready == 2'b10) ? 1 : 0;
        g_cyc[ng] = c;
        ng++;
      end
      step();
    end
    chk("t3_grants", ng, 4);
    for (int k = 0; k < 4; k++) chk("t3_grant_order", g_idx[k], k % 2);
    for (int k = 1; k < 4; k++) chk("t3_spacing", g_cyc[k] - g_cyc[k-1], 3);
    req_valid = '0;
    repeat (4) step();

    // 4: completer never ready -> timeout abort after TIMEOUT ACCESS cycles
    set_req(0, 1, 0, 6'h3F, '0); pready = 1'b0; prdata = 32'hFFFFFFFF;
    step();
    set_req(0, 0, 0, '0, '0);
    n_acc = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      if (psel && penable) n_acc++;
      step();
      if (rsp_valid != 0) got = 1;
    end
    chk("t4_done", got, 1); chk("t4_access_cycles", n_acc, TIMEOUT);
    chk("t4_rsp_valid", rsp_valid, 2'b01); chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_rdata", rsp_rdata, 0); chk("t4_psel_off", psel, 0);

    // 5: asynchronous reset in ACCESS; rotation restarts at requester 0
    step();
    set_req(0, 1, 1, 6'h07, 32'h0BADF00D); pready = 1'b0;
    step();
    set_req(0, 0, 0, '0, '0);
    step();
    chk("t5_in_access", penable, 1);
    #2 prst = 1'b1;
    #1;
    chk("t5_async_psel", psel, 0); chk("t5_async_penable", penable, 0);
    #2 prst = 1'b0;
    model_reset();
    repeat (3) step();
    set_req(0, 1, 0, 6'h01, '0); set_req(1, 1, 0, 6'h02, '0); pready = 1'b1;
    #1 chk("t5_first_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    repeat (4) step();

    // 6: random traffic, including a periodic stall long enough to time out
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i] || !req_valid[i]) begin
          if ($urandom_range(0, 99) < 45)
            set_req(i, 1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
          else
            set_req(i, 0, 0, '0, '0);
        end
      end
      pready = ((c % 200) >= 100 && (c % 200) < 125) ? 1'b0 : ($urandom_range(0, 3) != 0);
      prdata = $urandom;
      step();
    end
    req_valid = '0; pready = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
